// File: rtl/teclado_varredura.sv
// teclado_varredura: synchroniser, debouncer and one-hot key pulse generator
// for the four vending-machine selection buttons, plus the inactivity timer.
// Optional build macro TECLADO_TIMEOUT_EN: when defined the timeout timer is
// built and drives tempo; when undefined tempo is tied low and
// TIMEOUT_CYCLES has no effect.

module teclado_varredura #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] botao_n,
  input  logic       habilita,
  output logic [3:0] tecla,
  output logic       tempo
);

  // state     | meaning
  // OCIOSO    | no key seen; waits for any key pattern
  // FILTRANDO | pattern cand must stay unchanged DEBOUNCE_CYCLES cycles
  // EMITE     | one-cycle key pulse; (re)arms the inactivity timer
  // SOLTAR    | waits for a debounced full release before accepting again

  typedef enum logic [1:0] {OCIOSO, FILTRANDO, EMITE, SOLTAR} estado_t;

  localparam int unsigned   DW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("teclado_varredura: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 2");
  end

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    key_s;
  estado_t       estado_q, estado_d;
  logic [3:0]    cand_q, cand_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [3:0]    tecla_q, tecla_d;
  // solto: a debounced release has been seen since reset, so a key that was
  // already held across reset is never reported.
  logic          solto_q, solto_d;
  // vivo: the sync chain has refilled after reset and key_s reflects the pins.
  logic [1:0]    vivo_q, vivo_d;
  logic          cand_1hot;

  assign key_s     = ~sync2_q;
  assign cand_1hot = (cand_q != 4'b0) && ((cand_q & (cand_q - 4'd1)) == 4'b0);

  // Next-state logic for the debounce / emit / release sequence.
  always_comb begin
    estado_d = estado_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    tecla_d  = 4'b0;
    solto_d  = solto_q;
    vivo_d   = {vivo_q[0], 1'b1};
    case (estado_q)
      OCIOSO: begin
        if (!solto_q) begin
          if (!vivo_q[1] || key_s != 4'b0) begin
            cnt_d = '0;
          end else if (cnt_q == DB_LAST) begin
            cnt_d   = '0;
            solto_d = 1'b1;
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end else if (key_s != 4'b0) begin
          cand_d   = key_s;
          cnt_d    = '0;
          estado_d = FILTRANDO;
        end
      end
      FILTRANDO: begin
        if (key_s != cand_q) begin
          cnt_d    = '0;
          estado_d = OCIOSO;
        end else if (cnt_q == DB_LAST) begin
          cnt_d    = '0;
          estado_d = (cand_1hot && habilita) ? EMITE : SOLTAR;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      EMITE: begin
        tecla_d  = cand_q;
        cnt_d    = '0;
        estado_d = SOLTAR;
      end
      SOLTAR: begin
        if (key_s != 4'b0) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          cnt_d    = '0;
          estado_d = OCIOSO;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Synchroniser chain and FSM registers; buttons read as released in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 4'hF;
      sync2_q  <= 4'hF;
      estado_q <= OCIOSO;
      cand_q   <= 4'b0;
      cnt_q    <= '0;
      tecla_q  <= 4'b0;
      solto_q  <= 1'b0;
      vivo_q   <= 2'b00;
    end else begin
      sync1_q  <= botao_n;
      sync2_q  <= sync1_q;
      estado_q <= estado_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      tecla_q  <= tecla_d;
      solto_q  <= solto_d;
      vivo_q   <= vivo_d;
    end
  end

  assign tecla = tecla_q;

`ifdef TECLADO_TIMEOUT_EN
  localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TM_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          armado_q, armado_d;
  logic          tempo_q, tempo_d;

  // Inactivity timer: habilita low wins, then a new key restarts, then expiry.
  always_comb begin
    tmr_d    = tmr_q;
    armado_d = armado_q;
    tempo_d  = 1'b0;
    if (!habilita) begin
      tmr_d    = '0;
      armado_d = 1'b0;
    end else if (estado_q == EMITE) begin
      tmr_d    = '0;
      armado_d = 1'b1;
    end else if (armado_q) begin
      if (tmr_q == TM_LAST) begin
        tmr_d    = '0;
        armado_d = 1'b0;
        tempo_d  = 1'b1;
      end else begin
        tmr_d = tmr_q + TW'(1);
      end
    end
  end

  // Timer registers; disarmed after reset so no timeout before the first key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_q    <= '0;
      armado_q <= 1'b0;
      tempo_q  <= 1'b0;
    end else begin
      tmr_q    <= tmr_d;
      armado_q <= armado_d;
      tempo_q  <= tempo_d;
    end
  end

  assign tempo = tempo_q;
`else
  assign tempo = 1'b0;
`endif

endmodule
